// File: rtl/nes_io_pkg.sv
// Shared constants, scanner state encoding and small helpers for the
// NES controller-port responder.
package nes_io_pkg;

    localparam logic [15:0] JOY1_ADDR   = 16'h4016;
    localparam logic [15:0] JOY2_ADDR   = 16'h4017;
    localparam logic [6:0]  OPEN_BUS_HI = 7'b0100000;

    typedef enum int unsigned {
        BTN_A      = 0,
        BTN_B      = 1,
        BTN_SELECT = 2,
        BTN_START  = 3,
        BTN_UP     = 4,
        BTN_DOWN   = 5,
        BTN_LEFT   = 6,
        BTN_RIGHT  = 7
    } btn_idx_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        READ   = 3'd2,
        CLK_HI = 3'd3,
        DONE   = 3'd4
    } scan_state_e;

    // Serial-register shift as seen by the CPU: drained bits are replaced by 1.
    function automatic logic [7:0] shift_in_one(input logic [7:0] sh);
        return {1'b1, sh[7:1]};
    endfunction

    function automatic logic [7:0] bus_read_word(input logic btn_bit);
        return {OPEN_BUS_HI, btn_bit};
    endfunction

endpackage

// File: rtl/nes_joypad_io_if.sv
// CPU-side address/control group of the shared NES bus; the data lines stay a
// plain tristate net on the top module.
interface nes_joypad_io_if;
    logic [15:0] addr;
    logic        rw_n;
    logic        cs_n;

    modport master (output addr, rw_n, cs_n);
    modport slave  (input  addr, rw_n, cs_n);
endinterface

// File: rtl/nes_joypad_io_scanner.sv
// Autonomous serial scanner for two NES pads: synchronizers, latch/clock FSM
// and the atomically updated button snapshots.
module joypad_scanner
    import nes_io_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int SCAN_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pad_data1,
    input  logic       pad_data2,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons1,
    output logic [7:0] buttons2
);

    localparam int CW = 16;
    localparam logic [CW-1:0] IDLE_LAST  = CW'(SCAN_PERIOD - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    meta_q, sync_q;
    logic [7:0]    scan1_q, scan1_d;
    logic [7:0]    scan2_q, scan2_d;
    logic [7:0]    btn1_q, btn1_d;
    logic [7:0]    btn2_q, btn2_d;
    logic          latch_q, latch_d;
    logic          pclk_q, pclk_d;

    // Two-flop synchronizer for the asynchronous pad data lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {pad_data2, pad_data1};
            sync_q <= meta_q;
        end
    end

    // Scanner state, counters, scan shift registers and registered pad outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            scan1_q <= 8'h00;
            scan2_q <= 8'h00;
            btn1_q  <= 8'h00;
            btn2_q  <= 8'h00;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            scan1_q <= scan1_d;
            scan2_q <= scan2_d;
            btn1_q  <= btn1_d;
            btn2_q  <= btn2_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
        end
    end

    // Next-state logic; pad outputs are decoded from the next state so the
    // registered pins line up exactly with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        scan1_d = scan1_q;
        scan2_d = scan2_q;
        btn1_d  = btn1_q;
        btn2_d  = btn2_q;
        case (state_q)
            IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = READ;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end else begin
                    state_d = LATCH;
                end
            end
            READ: begin
                if (cnt_q == HALF_LAST) begin
                    // Pads drive active-low; store 1 = pressed.
                    scan1_d[idx_q] = ~sync_q[0];
                    scan2_d[idx_q] = ~sync_q[1];
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLK_HI;
                    end
                end else begin
                    state_d = READ;
                end
            end
            CLK_HI: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = READ;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    state_d = CLK_HI;
                end
            end
            DONE: begin
                btn1_d  = scan1_q;
                btn2_d  = scan2_q;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        latch_d = (state_d == LATCH);
        pclk_d  = (state_d == CLK_HI);
    end

    assign pad_latch = latch_q;
    assign pad_clk   = pclk_q;
    assign buttons1  = btn1_q;
    assign buttons2  = btn2_q;

endmodule

// File: rtl/nes_joypad_io.sv
// $4016/$4017 bus responder: strobe register, CPU-visible shift registers and
// the read-data tristate driver, fed by the autonomous pad scanner.
module nes_joypad_io
    import nes_io_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int SCAN_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nes_joypad_io_if.slave        bus,
    inout  wire  [7:0]            data,
    output logic                  pad_latch,
    output logic                  pad_clk,
    input  logic                  pad_data1,
    input  logic                  pad_data2
);

    logic [7:0] buttons1_s, buttons2_s;
    logic       sel1_s, sel2_s, rd_s, wr_s, drive_s;
    logic [7:0] rd_data_s;
    logic       strobe_q, strobe_d;
    logic [7:0] sh1_q, sh1_d;
    logic [7:0] sh2_q, sh2_d;

    joypad_scanner #(
        .CLK_DIV     (CLK_DIV),
        .SCAN_PERIOD (SCAN_PERIOD)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .pad_data1 (pad_data1),
        .pad_data2 (pad_data2),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .buttons1  (buttons1_s),
        .buttons2  (buttons2_s)
    );

    assign sel1_s = !bus.cs_n && (bus.addr == JOY1_ADDR);
    assign sel2_s = !bus.cs_n && (bus.addr == JOY2_ADDR);
    assign rd_s   = (sel1_s || sel2_s) &&  bus.rw_n;
    assign wr_s   = (sel1_s || sel2_s) && !bus.rw_n;

    assign rd_data_s = bus_read_word(sel2_s ? sh2_q[BTN_A] : sh1_q[BTN_A]);
    assign drive_s   = rd_s && !rst;
    assign data      = drive_s ? rd_data_s : 8'hzz;

    // Strobe and CPU-visible shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
        end else begin
            strobe_q <= strobe_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
        end
    end

    // Reload uses old-or-new strobe so that both the 0->1 write edge and the
    // final 1->0 write edge copy the button snapshot.
    always_comb begin
        strobe_d = strobe_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        if (wr_s && sel1_s) begin
            strobe_d = data[0];
        end else begin
            strobe_d = strobe_q;
        end
        if (strobe_q || strobe_d) begin
            sh1_d = buttons1_s;
            sh2_d = buttons2_s;
        end else if (rd_s && sel1_s) begin
            sh1_d = shift_in_one(sh1_q);
        end else if (rd_s && sel2_s) begin
            sh2_d = shift_in_one(sh2_q);
        end else begin
            sh1_d = sh1_q;
            sh2_d = sh2_q;
        end
    end

endmodule
